// File: rtl/parity_generator_pkg.sv
// Shared constants and the parity-reduction helper for the parity generator.
package parity_generator_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned WIDTH_MAX     = 64;

    // XOR reduction of a word zero-extended to the widest legal width.
    function automatic logic reduce_xor(input logic [WIDTH_MAX-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(WIDTH_MAX); i++) begin
            r = r ^ v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_generator_reduce.sv
// Purely combinational XOR tree producing the parity of one data word.
module parity_reduce
    import parity_generator_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_parity
);

    assign o_parity = reduce_xor(WIDTH_MAX'(i_data));

endmodule

// File: rtl/parity_generator.sv
// Registered even/odd parity generator with optional fold-in accumulation and clear.
module parity_generator
    import parity_generator_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    input  logic             acc,
    input  logic             clear,
    output logic             even,
    output logic             odd,
    output logic             out_valid
);

    logic r_even;
    logic r_odd;
    logic r_valid;
    logic w_word_par;
    logic w_fold;
    logic w_eff_par;

    parity_reduce #(
        .WIDTH(WIDTH)
    ) u_reduce (
        .i_data  (a),
        .o_parity(w_word_par)
    );

    // The stored even bit is the running parity; clear wins over accumulate.
    always_comb begin
        w_fold    = 1'b0;
        w_eff_par = 1'b0;
        if (acc && !clear) begin
            w_fold = r_even;
        end
        w_eff_par = w_word_par ^ w_fold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_even  <= 1'b0;
            r_odd   <= 1'b1;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_even  <= w_eff_par;
            r_odd   <= ~w_eff_par;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_even  <= 1'b0;
            r_odd   <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign even      = r_even;
    assign odd       = r_odd;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_parity_generator.sv
// Randomized and directed self-checking bench for parity_generator.
module tb_parity_generator;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic         in_valid;
    logic         acc;
    logic         clear;
    logic         even;
    logic         odd;
    logic         out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: total ones count of the words in the current run.
    int m_ones  = 0;
    bit m_valid = 1'b0;

    parity_generator #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .in_valid (in_valid),
        .acc      (acc),
        .clear    (clear),
        .even     (even),
        .odd      (odd),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popcount(input logic [W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

    function automatic bit m_even();
        return bit'(m_ones % 2);
    endfunction

    task automatic model_reset();
        m_ones  = 0;
        m_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".even"},  64'(even),      64'(m_even()));
        check({tag, ".odd"},   64'(odd),       64'(!m_even()));
        check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    endtask

    // Advance one edge, update the model with the inputs present at that edge, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (in_valid) begin
            if (acc && !clear) m_ones = m_ones + popcount(a);
            else               m_ones = popcount(a);
            m_valid = 1'b1;
        end else begin
            if (clear) m_ones = 0;
            m_valid = 1'b0;
        end
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit v, input bit ac, input bit cl, input logic [W-1:0] d);
        in_valid = v;
        acc      = ac;
        clear    = cl;
        a        = d;
    endtask

    task automatic async_reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".even"},  64'(even),      64'(0));
        check({tag, ".odd"},   64'(odd),       64'(1));
        check({tag, ".valid"}, 64'(out_valid), 64'(0));
        rst = 1'b0;
    endtask

    logic [W-1:0] seq_a   [4];
    bit           seq_exp [4];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check("reset.even",  64'(even),      64'(0));
        check("reset.odd",   64'(odd),       64'(1));
        check("reset.valid", 64'(out_valid), 64'(0));
        rst = 1'b0;
        model_reset();

        // First accept right after reset release.
        drive(1'b1, 1'b0, 1'b0, 4'b0111);
        tick("first_after_reset");
        check("first_after_reset.const", 64'(even), 64'(1));

        // Non-accumulating stream.
        seq_a[0] = 4'b0000; seq_exp[0] = 1'b0;
        seq_a[1] = 4'b1010; seq_exp[1] = 1'b0;
        seq_a[2] = 4'b0001; seq_exp[2] = 1'b1;
        seq_a[3] = 4'b1011; seq_exp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, seq_a[i]);
            tick("stream");
            check("stream.even_const", 64'(even), 64'(seq_exp[i]));
            check("stream.odd_const",  64'(odd),  64'(!seq_exp[i]));
        end

        // Accumulate: running ones 1, 3, 4.
        drive(1'b1, 1'b0, 1'b0, 4'b0001); tick("acc0");
        check("acc0.const", 64'(even), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 4'b0011); tick("acc1");
        check("acc1.const", 64'(even), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 4'b0100); tick("acc2");
        check("acc2.const", 64'(even), 64'(0));

        // Hold with in_valid low and noisy other inputs.
        drive(1'b1, 1'b0, 1'b0, 4'b0111); tick("hold_load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, W'($urandom_range(0, 15)));
            tick("hold");
            check("hold.even_const",  64'(even),      64'(1));
            check("hold.valid_const", 64'(out_valid), 64'(0));
        end

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 1'b0, 1'b0, 4'b0001); tick("pre_rst");
        drive(1'b0, 1'b0, 1'b0, '0);
        #2;
        async_reset_pulse("async_rst");
        drive(1'b1, 1'b1, 1'b0, 4'b0010); tick("acc_after_rst");
        check("acc_after_rst.const", 64'(even), 64'(1));

        // Clear together with accept ignores acc and prior parity.
        drive(1'b1, 1'b0, 1'b0, 4'b0001); tick("pre_clear");
        drive(1'b1, 1'b1, 1'b1, 4'b1000); tick("clear_accept");
        check("clear_accept.even_const",  64'(even),      64'(1));
        check("clear_accept.valid_const", 64'(out_valid), 64'(1));

        // Plain clear.
        drive(1'b0, 1'b0, 1'b1, 4'b1111); tick("clear_only");
        check("clear_only.even_const", 64'(even), 64'(0));
        drive(1'b1, 1'b0, 1'b0, 4'b1111); tick("all_ones");
        check("all_ones.const", 64'(even), 64'(W % 2));

        // Exhaustive sweep with acc=0.
        for (int v = 0; v < 16; v++) begin
            drive(1'b1, 1'b0, 1'b0, W'(v));
            tick("sweep");
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, W'($urandom_range(0, 15)));
            tick("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                async_reset_pulse("rand_rst");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
